// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port byte-addressable data memory.
// Port 1 (load/store) has priority; port 0 (fetch) is forced through after MAX_WAIT lost arbitrations.
`ifndef ML_BYTE
`define ML_BYTE 2'b00
`endif
`ifndef ML_HALF
`define ML_HALF 2'b01
`endif
`ifndef ML_WORD
`define ML_WORD 2'b10
`endif

module mem_arbiter #(
  parameter int ADDRW    = 12,
  parameter int MEM_RLAT = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p0_req,
  input  logic             p0_we,
  input  logic             p0_sign,
  input  logic [1:0]       p0_len,
  input  logic [ADDRW-1:0] p0_addr,
  input  logic [31:0]      p0_wdata,
  output logic             p0_gnt,
  output logic             p0_rvalid,
  input  logic             p0_rready,
  output logic [31:0]      p0_rdata,
  output logic             p0_err,
  input  logic             p1_req,
  input  logic             p1_we,
  input  logic             p1_sign,
  input  logic [1:0]       p1_len,
  input  logic [ADDRW-1:0] p1_addr,
  input  logic [31:0]      p1_wdata,
  output logic             p1_gnt,
  output logic             p1_rvalid,
  input  logic             p1_rready,
  output logic [31:0]      p1_rdata,
  output logic             p1_err,
  output logic             mem_we,
  output logic             mem_sign,
  output logic [1:0]       mem_len,
  output logic [ADDRW-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  function automatic logic misaligned(input logic [1:0] len, input logic [1:0] lsb);
    case (len)
      `ML_BYTE: misaligned = 1'b0;
      `ML_HALF: misaligned = lsb[0];
      `ML_WORD: misaligned = (lsb != 2'b00);
      default:  misaligned = 1'b1;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic [CW-1:0]    starve_q, starve_d;
  logic             wr_q, wr_d;
  logic [1:0]       rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             mem_we_q, mem_we_d;
  logic             mem_sign_q, mem_sign_d;
  logic [1:0]       mem_len_q, mem_len_d;
  logic [ADDRW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [1:0]       gnt_s;
  logic             win1_s;
  logic             sel_we_s;
  logic             sel_sign_s;
  logic [1:0]       sel_len_s;
  logic [ADDRW-1:0] sel_addr_s;
  logic [31:0]      sel_wdata_s;
  logic             own_rready_s;
  logic [1:0]       own_mask_s;

  assign win1_s       = p1_req & ~(p0_req & (starve_q == WAIT_MAX));
  assign sel_we_s     = win1_s ? p1_we    : p0_we;
  assign sel_sign_s   = win1_s ? p1_sign  : p0_sign;
  assign sel_len_s    = win1_s ? p1_len   : p0_len;
  assign sel_addr_s   = win1_s ? p1_addr  : p0_addr;
  assign sel_wdata_s  = win1_s ? p1_wdata : p0_wdata;
  assign own_rready_s = owner_q ? p1_rready : p0_rready;
  assign own_mask_s   = owner_q ? 2'b10 : 2'b01;

  // Next-state, arbitration and response capture
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    wr_d        = wr_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_sign_d  = mem_sign_q;
    mem_len_d   = mem_len_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    gnt_s       = 2'b00;
    case (state_q)
      IDLE: begin
        if (p0_req && win1_s) begin
          starve_d = (starve_q == WAIT_MAX) ? starve_q : starve_q + CW'(1);
        end else begin
          starve_d = '0;
        end
        if (p0_req || p1_req) begin
          gnt_s   = win1_s ? 2'b10 : 2'b01;
          owner_d = win1_s;
          wr_d    = sel_we_s;
          // Misaligned requests are answered directly; the memory bus is left untouched.
          if (misaligned(sel_len_s, sel_addr_s[1:0])) begin
            rdata_d  = 32'd0;
            err_d    = 1'b1;
            rvalid_d = gnt_s;
            state_d  = RESP;
          end else begin
            mem_we_d    = sel_we_s;
            mem_sign_d  = sel_sign_s;
            mem_len_d   = sel_len_s;
            mem_addr_d  = sel_addr_s;
            mem_wdata_d = sel_wdata_s;
            err_d       = 1'b0;
            state_d     = ACCESS;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (MEM_RLAT == 0) begin
          rdata_d  = wr_q ? 32'd0 : mem_rdata;
          rvalid_d = own_mask_s;
          state_d  = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        rdata_d  = wr_q ? 32'd0 : mem_rdata;
        rvalid_d = own_mask_s;
        state_d  = RESP;
      end
      RESP: begin
        if (own_rready_s) begin
          rvalid_d = 2'b00;
          state_d  = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      starve_q    <= '0;
      wr_q        <= 1'b0;
      rvalid_q    <= 2'b00;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_sign_q  <= 1'b0;
      mem_len_q   <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      wr_q        <= wr_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_sign_q  <= mem_sign_d;
      mem_len_q   <= mem_len_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // A reset landing in the ACCESS cycle must kill the store before the memory samples it.
  assign mem_we    = mem_we_q & ~rst;
  assign mem_sign  = mem_sign_q;
  assign mem_len   = mem_len_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign p0_gnt    = gnt_s[0] & ~rst;
  assign p1_gnt    = gnt_s[1] & ~rst;
  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  assign p0_rdata  = rvalid_q[0] ? rdata_q : 32'd0;
  assign p1_rdata  = rvalid_q[1] ? rdata_q : 32'd0;
  assign p0_err    = rvalid_q[0] & err_q;
  assign p1_err    = rvalid_q[1] & err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: instance 0 uses a combinational-read memory,
// instance 1 a registered-read memory; both memories are little-endian byte arrays.
module tb_mem_arbiter;
  localparam logic [1:0] LB = 2'b00, LH = 2'b01, LW = 2'b10;

  logic        clk, rst;
  logic [1:0]  req [2], we [2], sgn [2], rready [2], gnt [2], rvalid [2], err [2];
  logic [1:0]  len [2][2];
  logic [11:0] addr [2][2];
  logic [31:0] wdata [2][2], rdata [2][2];
  logic        mem_we [2], mem_sign [2];
  logic [1:0]  mem_len [2];
  logic [11:0] mem_addr [2];
  logic [31:0] mem_wdata [2], mem_rdata [2];
  logic [32:0] exp_q [4][$];
  int total = 0, bad = 0, cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] l, input logic s);
    case (l)
      2'b00:   ext = s ? {{24{w[7]}}, w[7:0]} : {24'd0, w[7:0]};
      2'b01:   ext = s ? {{16{w[15]}}, w[15:0]} : {16'd0, w[15:0]};
      default: ext = w;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0]  mem [4096];
    logic [31:0] rd_now, rd_q;
    logic [11:0] a;
    int          we_cnt = 0;
    initial for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    assign a      = mem_addr[g];
    assign rd_now = ext({mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]}, mem_len[g], mem_sign[g]);
    assign mem_rdata[g] = (g == 0) ? rd_now : rd_q;
    always @(posedge clk) begin
      rd_q <= rd_now;
      if (mem_we[g]) begin
        we_cnt <= we_cnt + 1;
        mem[a] <= mem_wdata[g][7:0];
        if (mem_len[g] != 2'b00) mem[a + 12'd1] <= mem_wdata[g][15:8];
        if (mem_len[g] == 2'b10) begin
          mem[a + 12'd2] <= mem_wdata[g][23:16];
          mem[a + 12'd3] <= mem_wdata[g][31:24];
        end
      end
    end
    mem_arbiter #(.ADDRW(12), .MEM_RLAT(g), .MAX_WAIT(4)) u_dut (
      .clk(clk), .rst(rst),
      .p0_req(req[g][0]), .p0_we(we[g][0]), .p0_sign(sgn[g][0]), .p0_len(len[g][0]),
      .p0_addr(addr[g][0]), .p0_wdata(wdata[g][0]), .p0_gnt(gnt[g][0]), .p0_rvalid(rvalid[g][0]),
      .p0_rready(rready[g][0]), .p0_rdata(rdata[g][0]), .p0_err(err[g][0]),
      .p1_req(req[g][1]), .p1_we(we[g][1]), .p1_sign(sgn[g][1]), .p1_len(len[g][1]),
      .p1_addr(addr[g][1]), .p1_wdata(wdata[g][1]), .p1_gnt(gnt[g][1]), .p1_rvalid(rvalid[g][1]),
      .p1_rready(rready[g][1]), .p1_rdata(rdata[g][1]), .p1_err(err[g][1]),
      .mem_we(mem_we[g]), .mem_sign(mem_sign[g]), .mem_len(mem_len[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]));
  end

  task automatic step();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input int p, input logic w, input logic s,
                       input logic [1:0] l, input logic [11:0] ad, input logic [31:0] wd);
    req[d][p] = 1'b1; we[d][p] = w; sgn[d][p] = s; len[d][p] = l; addr[d][p] = ad; wdata[d][p] = wd;
    #1;
  endtask

  task automatic set_req(input int d, input int p, input logic w, input logic s, input logic [1:0] l,
                         input logic [11:0] ad, input logic [31:0] wd, input logic [31:0] xd, input logic xe);
    exp_q[d*2+p].push_back({xe, xd});
    drive(d, p, w, s, l, ad, wd);
  endtask

  task automatic wait_gnt(input int d, input int p, output int gs);
    bit ok = 1'b0;
    gs = cyc;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (gnt[d][p]) begin ok = 1'b1; gs = cyc; end
      else step();
    end
    chk($sformatf("gnt d%0d p%0d", d, p), {31'd0, ok}, 32'd1);
    step();
    req[d][p] = 1'b0;
  endtask

  task automatic wait_resp(input int d, input int p, input int gs, input int lat, input int stall, input string tag);
    bit ok = 1'b0, other = 1'b0, stable = 1'b1;
    logic [32:0] e;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (rvalid[d][p^1]) other = 1'b1;
      if (rvalid[d][p]) ok = 1'b1;
      else step();
    end
    chk({tag, " rvalid"}, {31'd0, ok}, 32'd1);
    chk({tag, " sb"}, exp_q[d*2+p].size(), 32'd1);
    e = (exp_q[d*2+p].size() > 0) ? exp_q[d*2+p].pop_front() : 33'h0;
    if (ok) begin
      chk({tag, " latency"}, cyc - gs, lat);
      chk({tag, " rdata"}, rdata[d][p], e[31:0]);
      chk({tag, " err"}, {31'd0, err[d][p]}, {31'd0, e[32]});
      chk({tag, " other rvalid"}, {31'd0, other | rvalid[d][p^1]}, 32'd0);
      for (int i = 0; i < stall; i++) begin
        step();
        if (!rvalid[d][p] || rdata[d][p] !== e[31:0]) stable = 1'b0;
      end
      if (stall > 0) chk({tag, " stall stable"}, {31'd0, stable}, 32'd1);
      rready[d][p] = 1'b1;
      step();
      rready[d][p] = 1'b0;
      chk({tag, " rvalid drop"}, {31'd0, rvalid[d][p]}, 32'd0);
    end
  endtask

  task automatic chk_rst(input int d);
    chk($sformatf("rst ctl d%0d", d),
        {22'd0, gnt[d], rvalid[d], err[d], mem_we[d], mem_sign[d], mem_len[d]}, 32'd0);
    chk($sformatf("rst rdata d%0d", d), rdata[d][0] | rdata[d][1], 32'd0);
    chk($sformatf("rst mem bus d%0d", d), {20'd0, mem_addr[d]} | mem_wdata[d], 32'd0);
  endtask

  initial begin
    int gs, c, n1;
    bit ok;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 2'b00; we[d] = 2'b00; sgn[d] = 2'b00; rready[d] = 2'b00;
      for (int p = 0; p < 2; p++) begin len[d][p] = LB; addr[d][p] = 12'd0; wdata[d][p] = 32'd0; end
    end
    repeat (3) step();
    chk_rst(0);
    chk_rst(1);
    rst = 1'b0;
    step();

    // Store word then signed byte load, combinational memory
    c = g_dut[0].we_cnt;
    set_req(0, 1, 1'b1, 1'b0, LW, 12'h010, 32'hDEADBEEF, 32'd0, 1'b0);
    wait_gnt(0, 1, gs);
    wait_resp(0, 1, gs, 2, 0, "st word");
    chk("st we cycles", g_dut[0].we_cnt - c, 32'd1);
    c = g_dut[0].we_cnt;
    set_req(0, 1, 1'b0, 1'b1, LB, 12'h013, 32'd0, 32'hFFFFFFDE, 1'b0);
    wait_gnt(0, 1, gs);
    wait_resp(0, 1, gs, 2, 0, "ld sbyte");
    chk("ld no we", g_dut[0].we_cnt - c, 32'd0);

    // Simultaneous requests: port 1 first, port 0 in the next IDLE
    set_req(0, 0, 1'b0, 1'b0, LW, 12'h010, 32'd0, 32'hDEADBEEF, 1'b0);
    set_req(0, 1, 1'b0, 1'b0, LB, 12'h010, 32'd0, 32'h000000EF, 1'b0);
    chk("simul gnt", {30'd0, gnt[0]}, 32'd2);
    wait_gnt(0, 1, gs);
    wait_resp(0, 1, gs, 2, 0, "simul p1");
    c = cyc;
    wait_gnt(0, 0, gs);
    chk("simul p0 next idle", gs, c);
    wait_resp(0, 0, gs, 2, 0, "simul p0");

    // Starvation: both held, port 0 gets in after exactly MAX_WAIT port-1 grants
    drive(0, 0, 1'b0, 1'b0, LW, 12'h010, 32'd0);
    drive(0, 1, 1'b0, 1'b0, LB, 12'h010, 32'd0);
    n1 = 0;
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      rready[0] = 2'b00;
      if (gnt[0][0]) ok = 1'b1;
      else begin
        if (gnt[0][1]) n1++;
        if (rvalid[0][1]) begin
          chk("starve p1 rdata", rdata[0][1], 32'h000000EF);
          rready[0][1] = 1'b1;
        end
        step();
      end
    end
    chk("starve p0 gnt", {31'd0, ok}, 32'd1);
    chk("starve p1 grants", n1, 32'd4);
    gs = cyc;
    exp_q[0].push_back({1'b0, 32'hDEADBEEF});
    step();
    req[0] = 2'b00;
    chk("starve cnt clear", {29'd0, g_dut[0].u_dut.starve_q}, 32'd0);
    wait_resp(0, 0, gs, 2, 0, "starve p0");

    // Misaligned and invalid-length requests never touch memory
    c = g_dut[0].we_cnt;
    set_req(0, 0, 1'b0, 1'b0, LH, 12'h005, 32'd0, 32'd0, 1'b1);
    wait_gnt(0, 0, gs);
    wait_resp(0, 0, gs, 1, 0, "mis half");
    set_req(0, 0, 1'b1, 1'b0, LW, 12'h006, 32'h12345678, 32'd0, 1'b1);
    wait_gnt(0, 0, gs);
    wait_resp(0, 0, gs, 1, 0, "mis word");
    set_req(0, 1, 1'b0, 1'b0, 2'b11, 12'h000, 32'd0, 32'd0, 1'b1);
    wait_gnt(0, 1, gs);
    wait_resp(0, 1, gs, 1, 0, "bad len");
    chk("mis no we", g_dut[0].we_cnt - c, 32'd0);

    // Registered-read memory: store, then unsigned half load with address held through WAIT
    set_req(1, 1, 1'b1, 1'b0, LW, 12'h010, 32'hA5A51234, 32'd0, 1'b0);
    wait_gnt(1, 1, gs);
    wait_resp(1, 1, gs, 3, 0, "r1 st");
    set_req(1, 1, 1'b0, 1'b0, LH, 12'h012, 32'd0, 32'h0000A5A5, 1'b0);
    wait_gnt(1, 1, gs);
    chk("r1 access addr", {20'd0, mem_addr[1]}, 32'h012);
    step();
    chk("r1 wait addr", {20'd0, mem_addr[1]}, 32'h012);
    chk("r1 wait we/len", {29'd0, mem_we[1], mem_len[1]}, 32'd1);
    wait_resp(1, 1, gs, 3, 0, "r1 ld half");

    // Reset during WAIT aborts with no response; the next request completes
    set_req(1, 0, 1'b0, 1'b0, LW, 12'h010, 32'd0, 32'hA5A51234, 1'b0);
    wait_gnt(1, 0, gs);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(exp_q[2].pop_front());
    chk_rst(1);
    step();
    chk("post rst rvalid", {30'd0, rvalid[1]}, 32'd0);
    set_req(1, 0, 1'b0, 1'b0, LW, 12'h010, 32'd0, 32'hA5A51234, 1'b0);
    wait_gnt(1, 0, gs);
    wait_resp(1, 0, gs, 3, 0, "r1 after rst");

    // Reset in the ACCESS cycle drops the store
    set_req(0, 1, 1'b1, 1'b0, LW, 12'h020, 32'h11111111, 32'd0, 1'b0);
    wait_gnt(0, 1, gs);
    chk("drop access we", {31'd0, mem_we[0]}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(exp_q[1].pop_front());
    chk_rst(0);
    set_req(0, 1, 1'b0, 1'b0, LW, 12'h020, 32'd0, 32'd0, 1'b0);
    wait_gnt(0, 1, gs);
    wait_resp(0, 1, gs, 2, 0, "dropped store");

    // rready stall keeps the response stable
    set_req(0, 1, 1'b0, 1'b0, LW, 12'h010, 32'd0, 32'hDEADBEEF, 1'b0);
    wait_gnt(0, 1, gs);
    wait_resp(0, 1, gs, 2, 5, "stall");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
